// File: rtl/gouram_trace_collector_pkg.sv
// Shared types for the trace collector: capture FSM states and channel-id sizing.
// Latency and backpressure are not applicable because this package holds types only.
package gouram_trace_collector_pkg;

  typedef enum logic [0:0] {
    CAPTURING = 1'b0,
    LOCKED    = 1'b1
  } capture_state_e;

  localparam int unsigned DROP_WIDTH = 16;

  function automatic int unsigned ch_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gouram_trace_collector_fifo.sv
// Synchronous FIFO for trace records. A pushed entry becomes visible one cycle later.
// Backpressure: a push is refused when the FIFO is full, unless an entry is popped in the same cycle.
module gouram_trace_collector_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push_ok;

  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  assign push_ok = push && ((count < DEPTH_CNT) || pop);
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gouram_trace_collector.sv
// Merges tracker record streams into a single timestamped stream, with a capture/lock FSM and a drop counter.
// Latency: an accepted record appears on trace_valid one cycle later. Backpressure: channels are stalled, and drops counted, while the FIFO is full.
module gouram_trace_collector
  import gouram_trace_collector_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned RECORD_WIDTH  = 64,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          WRAP_COUNTER  = 1'b1,
  localparam int unsigned CH_W         = ch_id_width(NUM_CHANNELS)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_CHANNELS-1:0]                 ch_valid,
  input  logic [NUM_CHANNELS*RECORD_WIDTH-1:0]    ch_data,
  output logic [NUM_CHANNELS-1:0]                 ch_ready,
  input  logic                                    repeat_detected,
  input  logic                                    unlock,
  output logic                                    trace_valid,
  output logic [COUNTER_WIDTH+CH_W+RECORD_WIDTH-1:0] trace_data,
  input  logic                                    trace_ready,
  output logic                                    trace_capture_enable,
  output logic                                    lock,
  output logic [COUNTER_WIDTH-1:0]                counter_o,
  output logic [DROP_WIDTH-1:0]                   drop_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CHANNELS - 1);

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] ts;
    logic [CH_W-1:0]          ch;
    logic [RECORD_WIDTH-1:0]  payload;
  } trace_hdr_t;

  capture_state_e   state;
  logic             run;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  idx;
  logic [CH_W-1:0]  grant_id;
  logic             grant_vld;
  logic             accept;
  logic             fifo_free;
  logic             out_pop;
  logic [CNT_W-1:0] fifo_count;
  trace_hdr_t       push_dat;
  trace_hdr_t       out_dat;

  // Round-robin search starting at rr_ptr, which holds the channel after the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CHANNELS);
      if (!grant_vld && ch_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign out_pop   = trace_valid && trace_ready;
  assign fifo_free = (fifo_count < DEPTH_CNT) || out_pop;
  // run keeps ch_ready low until the counter has left its reset value, so no record is stamped with all-ones.
  assign accept    = run && (state == CAPTURING) && fifo_free && grant_vld;

  always_comb begin
    ch_ready = '0;
    if (accept) begin
      ch_ready[grant_id] = 1'b1;
    end
  end

  assign push_dat.ts      = counter_o;
  assign push_dat.ch      = grant_id;
  assign push_dat.payload = ch_data[RECORD_WIDTH*grant_id +: RECORD_WIDTH];
  assign trace_data       = out_dat;

  gouram_trace_collector_fifo #(
    .WIDTH ($bits(trace_hdr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (push_dat),
    .out_vld  (trace_valid),
    .out_rdy  (trace_ready),
    .out_dat  (out_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_o <= '1;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (!run) begin
        counter_o <= '0;
      end else if (WRAP_COUNTER || (counter_o != '1)) begin
        counter_o <= counter_o + 1'b1;
      end
    end
  end

  // In LOCKED, unlock wins over a simultaneous repeat_detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= CAPTURING;
      trace_capture_enable <= 1'b1;
      lock                 <= 1'b0;
    end else begin
      case (state)
        CAPTURING: begin
          if (repeat_detected) begin
            state                <= LOCKED;
            trace_capture_enable <= 1'b0;
            lock                 <= 1'b1;
          end
        end
        LOCKED: begin
          if (unlock) begin
            state                <= CAPTURING;
            trace_capture_enable <= 1'b1;
            lock                 <= 1'b0;
          end
        end
        default: begin
          state                <= CAPTURING;
          trace_capture_enable <= 1'b1;
          lock                 <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
      end
      if (run && (state == CAPTURING) && (|ch_valid) && !fifo_free && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gouram_trace_collector.sv
// Scoreboarded bench for the trace collector: directed stimulus pushes expected records, a monitor pops and compares.
// Also runs two small 4-bit counter instances to cover the saturating and wrapping counter modes.
module tb_gouram_trace_collector;

  localparam int N   = 4;
  localparam int RW  = 64;
  localparam int CW  = 32;
  localparam int CHW = 2;
  localparam int DW  = CW + CHW + RW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    ch_valid;
  logic [N-1:0]    ch_ready;
  logic [N*RW-1:0] ch_data;
  logic            repeat_detected;
  logic            unlock;
  logic            trace_valid;
  logic [DW-1:0]   trace_data;
  logic            trace_ready;
  logic            cap_en;
  logic            lock;
  logic [CW-1:0]   counter;
  logic [15:0]     drop_count;

  logic [1:0]  s_ready, w_ready;
  logic        s_tv, w_tv, s_cap, w_cap, s_lock, w_lock;
  logic [12:0] s_td, w_td;
  logic [3:0]  s_cnt, w_cnt;
  logic [15:0] s_drop, w_drop;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [DW-1:0] exp_q[$];

  gouram_trace_collector dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .repeat_detected(repeat_detected), .unlock(unlock), .trace_valid(trace_valid),
    .trace_data(trace_data), .trace_ready(trace_ready), .trace_capture_enable(cap_en),
    .lock(lock), .counter_o(counter), .drop_count(drop_count)
  );

  gouram_trace_collector #(.NUM_CHANNELS(2), .RECORD_WIDTH(8), .COUNTER_WIDTH(4),
                           .FIFO_DEPTH(2), .WRAP_COUNTER(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ch_valid(2'b00), .ch_data(16'h0000), .ch_ready(s_ready),
    .repeat_detected(1'b0), .unlock(1'b0), .trace_valid(s_tv), .trace_data(s_td),
    .trace_ready(1'b1), .trace_capture_enable(s_cap), .lock(s_lock), .counter_o(s_cnt),
    .drop_count(s_drop)
  );

  gouram_trace_collector #(.NUM_CHANNELS(2), .RECORD_WIDTH(8), .COUNTER_WIDTH(4),
                           .FIFO_DEPTH(2), .WRAP_COUNTER(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ch_valid(2'b00), .ch_data(16'h0000), .ch_ready(w_ready),
    .repeat_detected(1'b0), .unlock(1'b0), .trace_valid(w_tv), .trace_data(w_td),
    .trace_ready(1'b1), .trace_capture_enable(w_cap), .lock(w_lock), .counter_o(w_cnt),
    .drop_count(w_drop)
  );

  // Cycles since reset release: the DUT counter reads cyc-1 once the first edge has passed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [CW-1:0] ts_now();
    return (cyc == 0) ? '1 : CW'(cyc - 1);
  endfunction

  function automatic logic [RW-1:0] pay(input int ch);
    return {16'hC0DE, 16'(ch), 32'h1234_5678 ^ 32'(ch * 3)};
  endfunction

  function automatic logic [DW-1:0] rec(input logic [CW-1:0] ts, input int ch);
    return {ts, CHW'(ch), pay(ch)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: got %h expected none", trace_data);
      end else begin
        chk("trace_data", trace_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] c;
    ch_valid = '0; repeat_detected = 0; unlock = 0; trace_ready = 0; rst_n = 0;
    for (int i = 0; i < N; i++) ch_data[i*RW +: RW] = pay(i);

    // Reset values, with channels requesting to prove ch_ready stays low.
    #12;
    ch_valid = '1;
    #1;
    chk("rst_counter", counter, {CW{1'b1}});
    chk("rst_cap_en", cap_en, 1'b1);
    chk("rst_lock", lock, 1'b0);
    chk("rst_trace_valid", trace_valid, 1'b0);
    chk("rst_ch_ready", ch_ready, 4'h0);
    chk("rst_drop", drop_count, 16'd0);
    chk("rst_sat_counter", s_cnt, 4'hF);
    ch_valid = '0;
    #9 rst_n = 1;

    // Idle counting; the 4-bit instances saturate at F or wrap to 0.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      c = 5'(cyc - 1);
      chk("idle_counter", counter, ts_now());
      chk("sat_counter", s_cnt, (c > 5'd15) ? 4'hF : c[3:0]);
      chk("wrap_counter", w_cnt, c[3:0]);
    end
    chk("idle_cap_en", cap_en, 1'b1);
    chk("idle_lock", lock, 1'b0);
    chk("idle_trace_valid", trace_valid, 1'b0);

    // All channels valid, consumer ready: grants rotate 0,1,2,3 with consecutive timestamps.
    next_cycle();
    ch_valid = '1; trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", ch_ready, 4'b0001 << (i % 4));
      exp_q.push_back(rec(ts_now(), i % 4));
      next_cycle();
    end
    ch_valid = '0;
    drain();

    // Consumer stalled: ch0 fills the 8-entry FIFO, then is blocked and drops accumulate.
    next_cycle();
    trace_ready = 0; ch_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fill_accept", ch_ready, 4'b0001);
      exp_q.push_back(rec(ts_now(), 0));
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_block", ch_ready, 4'b0000);
      next_cycle();
    end
    trace_ready = 1;
    @(negedge clk);
    chk("drop_count_full", drop_count, 16'd3);
    chk("full_pop_frees", ch_ready, 4'b0001);
    exp_q.push_back(rec(ts_now(), 0));
    next_cycle();
    ch_valid = '0;
    @(negedge clk);
    chk("drop_no_incr_on_pop", drop_count, 16'd3);
    drain();

    // Lock: grants resume from ch1, repeat_detected locks, FIFO drains while locked.
    next_cycle();
    trace_ready = 0; ch_valid = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pre_lock_grant", ch_ready, 4'b0001 << (i + 1));
      exp_q.push_back(rec(ts_now(), i + 1));
      next_cycle();
    end
    ch_valid = '0; repeat_detected = 1;
    @(negedge clk);
    chk("lock_not_yet", lock, 1'b0);
    next_cycle();
    repeat_detected = 0; ch_valid = '1; trace_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("locked_lock", lock, 1'b1);
      chk("locked_cap_en", cap_en, 1'b0);
      chk("locked_ch_ready", ch_ready, 4'b0000);
      next_cycle();
    end
    chk("locked_drained", trace_valid, 1'b0);
    chk("locked_no_drops", drop_count, 16'd3);
    unlock = 1; repeat_detected = 1;
    @(negedge clk);
    chk("unlock_cycle_lock", lock, 1'b1);
    next_cycle();
    unlock = 0; repeat_detected = 0;
    @(negedge clk);
    chk("unlock_wins", lock, 1'b0);
    chk("unlock_cap_en", cap_en, 1'b1);
    chk("resume_grant0", ch_ready, 4'b0001);
    exp_q.push_back(rec(ts_now(), 0));
    next_cycle();
    repeat_detected = 1; unlock = 1;
    @(negedge clk);
    chk("resume_grant1", ch_ready, 4'b0010);
    exp_q.push_back(rec(ts_now(), 1));
    next_cycle();
    repeat_detected = 0; unlock = 0; ch_valid = '0;
    @(negedge clk);
    chk("both_in_capturing_locks", lock, 1'b1);
    next_cycle();
    unlock = 1;
    next_cycle();
    unlock = 0;
    @(negedge clk);
    chk("unlock_alone", lock, 1'b0);
    drain();

    // Asynchronous reset with 5 records queued: everything is discarded.
    next_cycle();
    trace_ready = 0; ch_valid = 4'b0001;
    for (int i = 0; i < 5; i++) next_cycle();
    ch_valid = '0;
    @(negedge clk);
    chk("pre_reset_valid", trace_valid, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("arst_trace_valid", trace_valid, 1'b0);
    chk("arst_lock", lock, 1'b0);
    chk("arst_cap_en", cap_en, 1'b1);
    chk("arst_drop", drop_count, 16'd0);
    chk("arst_counter", counter, {CW{1'b1}});
    ch_valid = 4'b0001;
    #1;
    chk("arst_ch_ready", ch_ready, 4'b0000);
    ch_valid = '0; trace_ready = 1;
    #10 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_empty", trace_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
